// File: rtl/tdm_demux18_if.sv
// Bundle of the serial-link inputs and parallel-frame outputs of the 8-slot TDM demux.
// master drives the link side; slave is the demux itself.
interface tdm_demux18_if #(
   parameter int WIDTH = 1
);
   logic                 en;
   logic                 sync;
   logic [WIDTH-1:0]     din;
   logic [8*WIDTH-1:0]   y;
   logic                 frame_valid;
   logic                 locked;
   logic [2:0]           slot;
   logic                 sync_err;

   modport master (
      output en, sync, din,
      input  y, frame_valid, locked, slot, sync_err
   );

   modport slave (
      input  en, sync, din,
      output y, frame_valid, locked, slot, sync_err
   );
endinterface

// File: rtl/tdm_demux18.sv
// Receive side of an 8-slot TDM link: locks to the slot-0 sync marker, collects one sample per
// enabled cycle and publishes each complete frame as a registered 8-slot word with a strobe.
module tdm_demux18 #(
   parameter int WIDTH    = 1,
   parameter int MISS_MAX = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   tdm_demux18_if.slave     bus
);
   localparam logic [0:0] S_HUNT   = 1'b0;
   localparam logic [0:0] S_LOCKED = 1'b1;
   localparam logic [2:0] MISS_LIM = 3'(MISS_MAX);

   logic [0:0]           r_state;
   logic [WIDTH-1:0]     r_shadow [0:7];
   logic [8*WIDTH-1:0]   r_y;
   logic                 r_frame_valid;
   logic                 r_sync_err;
   logic [2:0]           r_slot;
   logic [2:0]           r_miss;

   logic [2:0]           w_miss_inc;
   logic [8*WIDTH-1:0]   w_frame;

   assign w_miss_inc = r_miss + 3'd1;

   // The completed frame is slots 0..6 from the shadow plus the slot-7 sample arriving now.
   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_pack
         assign w_frame[gi*WIDTH +: WIDTH] = r_shadow[gi];
      end
   endgenerate
   assign w_frame[7*WIDTH +: WIDTH] = bus.din;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_HUNT;
         r_y           <= '0;
         r_frame_valid <= 1'b0;
         r_sync_err    <= 1'b0;
         r_slot        <= 3'd0;
         r_miss        <= 3'd0;
         for (int i = 0; i < 8; i++) r_shadow[i] <= '0;
      end else begin
         r_frame_valid <= 1'b0;
         r_sync_err    <= 1'b0;
         if (bus.en) begin
            if (r_state == S_HUNT) begin
               if (bus.sync) begin
                  r_shadow[0] <= bus.din;
                  r_slot      <= 3'd1;
                  r_miss      <= 3'd0;
                  r_state     <= S_LOCKED;
               end
            end else if (bus.sync) begin
               // Sync always realigns; if it arrives early the partial frame is thrown away.
               if (r_slot != 3'd0) begin
                  r_sync_err <= 1'b1;
                  for (int i = 1; i < 8; i++) r_shadow[i] <= '0;
               end
               r_shadow[0] <= bus.din;
               r_slot      <= 3'd1;
               r_miss      <= 3'd0;
            end else if (r_slot == 3'd0) begin
               r_miss <= w_miss_inc;
               if (w_miss_inc >= MISS_LIM) begin
                  r_state <= S_HUNT;
                  r_slot  <= 3'd0;
               end else begin
                  r_shadow[0] <= bus.din;
                  r_slot      <= 3'd1;
               end
            end else if (r_slot == 3'd7) begin
               r_y           <= w_frame;
               r_frame_valid <= 1'b1;
               r_slot        <= 3'd0;
            end else begin
               r_shadow[r_slot] <= bus.din;
               r_slot           <= r_slot + 3'd1;
            end
         end
      end
   end

   assign bus.y           = r_y;
   assign bus.frame_valid = r_frame_valid;
   assign bus.locked      = (r_state == S_LOCKED);
   assign bus.slot        = r_slot;
   assign bus.sync_err    = r_sync_err;
endmodule

// File: tb/tb_tdm_demux18.sv
// Drives a 1-bit and a 4-bit demux with the same slot timing and checks both against a
// queue-based frame model; directed scenarios first, then randomized traffic.
module tb_tdm_demux18;
   localparam int MISS = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tdm_demux18_if #(.WIDTH(1)) bus1();
   tdm_demux18_if #(.WIDTH(4)) bus4();

   tdm_demux18 #(.WIDTH(1), .MISS_MAX(MISS)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   tdm_demux18 #(.WIDTH(4), .MISS_MAX(MISS)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference model: samples since the last alignment point are kept in a queue; its length
   // is the slot of the next expected sample, and eight entries make a frame.
   bit          m_locked;
   int          m_miss;
   logic [3:0]  m_q[$];
   logic [31:0] m_y4;
   logic [7:0]  m_y1;
   bit          m_fv;
   bit          m_err;
   int          n_frames;

   function automatic void model_reset();
      m_locked = 0; m_miss = 0; m_q.delete();
      m_y4 = '0; m_y1 = '0; m_fv = 0; m_err = 0;
   endfunction

   function automatic void model_step(input bit s, input logic [3:0] d);
      m_fv = 0;
      m_err = 0;
      if (!m_locked) begin
         if (s) begin
            m_q.delete(); m_q.push_back(d); m_locked = 1; m_miss = 0;
         end
      end else if (s) begin
         m_err = (m_q.size() != 0);
         m_q.delete(); m_q.push_back(d); m_miss = 0;
      end else if (m_q.size() == 0) begin
         m_miss++;
         if (m_miss >= MISS) m_locked = 0;
         else m_q.push_back(d);
      end else begin
         m_q.push_back(d);
         if (m_q.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
               m_y4[k*4 +: 4] = m_q[k];
               m_y1[k]        = m_q[k][0];
            end
            m_fv = 1;
            m_q.delete();
         end
      end
   endfunction

   task automatic compare_all(input string ctx);
      logic [2:0] exp_slot;
      exp_slot = m_locked ? 3'(m_q.size()) : 3'd0;
      check({ctx, " y1"},     32'(bus1.y),           32'(m_y1));
      check({ctx, " y4"},     bus4.y,                m_y4);
      check({ctx, " fv1"},    32'(bus1.frame_valid), 32'(m_fv));
      check({ctx, " fv4"},    32'(bus4.frame_valid), 32'(m_fv));
      check({ctx, " lock1"},  32'(bus1.locked),      32'(m_locked));
      check({ctx, " lock4"},  32'(bus4.locked),      32'(m_locked));
      check({ctx, " slot1"},  32'(bus1.slot),        32'(exp_slot));
      check({ctx, " slot4"},  32'(bus4.slot),        32'(exp_slot));
      check({ctx, " serr1"},  32'(bus1.sync_err),    32'(m_err));
      check({ctx, " serr4"},  32'(bus4.sync_err),    32'(m_err));
   endtask

   task automatic step(input string ctx, input bit e, input bit s, input logic [3:0] d);
      bus1.en = e; bus1.sync = s; bus1.din = d[0];
      bus4.en = e; bus4.sync = s; bus4.din = d;
      if (e) model_step(s, d);
      else begin m_fv = 0; m_err = 0; end
      @(posedge clk);
      #1;
      if (bus1.frame_valid) n_frames++;
      compare_all(ctx);
   endtask

   // One frame of eight enabled samples; nibble k of v is the slot-k sample.
   task automatic frame(input string ctx, input bit s0, input logic [31:0] v);
      for (int k = 0; k < 8; k++) step(ctx, 1'b1, s0 && (k == 0), v[k*4 +: 4]);
   endtask

   initial begin
      bus1.en = 0; bus1.sync = 0; bus1.din = '0;
      bus4.en = 0; bus4.sync = 0; bus4.din = '0;
      model_reset();
      n_frames = 0;
      #1;
      compare_all("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      compare_all("release");

      // Alternating pattern, sync on the first sample.
      frame("t1", 1'b1, 32'h0101_0101);
      check("t1 y55", 32'(bus1.y), 32'h55);
      $display("t1 frame y1=%h y4=%h", bus1.y, bus4.y);

      // Same frame with idle cycles between samples; sync on idle cycles must be ignored.
      n_frames = 0;
      for (int k = 0; k < 8; k++) begin
         step("t2 idle", 1'b0, 1'b1, 4'hE);
         step("t2", 1'b1, k == 0, (k % 2 == 0) ? 4'h1 : 4'h0);
      end
      check("t2 y55", 32'(bus1.y), 32'h55);
      check("t2 frames", 32'(n_frames), 32'd1);
      $display("t2 frame y1=%h frames=%0d", bus1.y, n_frames);

      // Early sync at slot 5, then seven ones complete a frame.
      for (int k = 0; k < 5; k++) step("t3 pre", 1'b1, k == 0, 4'h3);
      step("t3 early", 1'b1, 1'b1, 4'hF);
      check("t3 serr", 32'(bus1.sync_err), 32'd1);
      check("t3 yhold", 32'(bus1.y), 32'h55);
      for (int k = 0; k < 7; k++) step("t3 post", 1'b1, 1'b0, 4'hF);
      check("t3 yFF", 32'(bus1.y), 32'hFF);
      $display("t3 frame y1=%h", bus1.y);

      // Synced frame, then two unsynced: the first flywheels, lock drops at the second.
      frame("t4 a", 1'b1, 32'h1234_5678);
      frame("t4 b", 1'b0, 32'h9ABC_DEF0);
      check("t4 flywheel y4", bus4.y, 32'h9ABC_DEF0);
      step("t4 miss", 1'b1, 1'b0, 4'h5);
      check("t4 unlocked", 32'(bus4.locked), 32'd0);
      for (int k = 0; k < 7; k++) step("t4 hunt", 1'b1, 1'b0, 4'h6);
      $display("t4 locked=%0d y4=%h", bus4.locked, bus4.y);

      // Asynchronous reset in the middle of a frame.
      for (int k = 0; k < 4; k++) step("t5 pre", 1'b1, k == 0, 4'h7);
      rst_n = 1'b0;
      model_reset();
      #2;
      compare_all("t5 async");
      check("t5 y0", bus4.y, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) step("t5 nosync", 1'b1, 1'b0, 4'h9);
      check("t5 stays unlocked", 32'(bus1.locked), 32'd0);
      $display("t5 after reset locked=%0d", bus1.locked);

      // Continuous frames with slot k carrying k+1.
      n_frames = 0;
      for (int f = 0; f < 3; f++) frame("t6", 1'b1, 32'h8765_4321);
      check("t6 y4", bus4.y, 32'h8765_4321);
      check("t6 frames", 32'(n_frames), 32'd3);
      $display("t6 frames=%0d y4=%h", n_frames, bus4.y);

      // Random traffic: mostly well-formed frames with idle cycles, stray and missing syncs.
      begin
         int pos = 0;
         for (int i = 0; i < 1500; i++) begin
            bit e, s;
            e = ($urandom % 4) != 0;
            s = ((pos == 0) && (($urandom % 8) != 0)) || (($urandom % 40) == 0);
            step("rand", e, s, 4'($urandom));
            if (e) pos = (s ? 1 : pos + 1) % 8;
         end
      end
      $display("random phase done frames_seen=%0d", n_frames);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
